// File: rtl/iq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : iq_pkg                                                       |
// | Description : Shared types, default widths and saturating-add helpers for  |
// |               the I/Q demodulation chain (multiplier, integrator, binning).|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package iq_pkg;

   localparam int DEF_LANES  = 5;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ACC_W  = 32;
   localparam int DEF_LEN_W  = 11;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INTEGRATE = 2'd1,
      DRAIN     = 2'd2,
      HOLD      = 2'd3
   } state_t;

   // Signed limits of a w-bit two's complement value, carried in 64 bits.
   function automatic logic signed [63:0] acc_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] acc_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   localparam logic signed [63:0] ACC_MAX = acc_max(DEF_ACC_W);
   localparam logic signed [63:0] ACC_MIN = acc_min(DEF_ACC_W);

   // a + b at full precision, clamped into the w-bit signed range.
   // The caller truncates the result to w bits.
   function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                           input logic signed [63:0] b,
                                           input int                 w);
      logic signed [64:0] s;
      logic [63:0]        r;
      s = 65'(a) + 65'(b);
      r = s[63:0];
      if (s > 65'(acc_max(w))) begin
         r = acc_max(w);
      end else if (s < 65'(acc_min(w))) begin
         r = acc_min(w);
      end
      return r;
   endfunction

   // Companion of sat_add: 1 when the clamp engaged.
   function automatic logic sat_ovf(input logic signed [63:0] a,
                                    input logic signed [63:0] b,
                                    input int                 w);
      logic signed [64:0] s;
      s = 65'(a) + 65'(b);
      return (s > 65'(acc_max(w))) || (s < 65'(acc_min(w)));
   endfunction

endpackage : iq_pkg
`default_nettype wire

// File: rtl/iq_lane_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iq_lane_sum                                                  |
// | Description : Masked, sign-extending, registered adder of LANES samples.   |
// |               One instance per quadrature.                                 |
// | Ports       : clk_i/rst_ni  clock, async active-low reset                  |
// |               flush_i       clears the output valid bit                    |
// |               en_i          load a new lane sum this cycle                 |
// |               mask_i        per-lane enable (0 = lane contributes 0)       |
// |               data_i        packed signed samples, lane 0 in LSBs          |
// |               sum_o/valid_o registered sum and its valid bit               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module iq_lane_sum
   import iq_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       en_i,
   input  logic [LANES-1:0]           mask_i,
   input  logic [LANES*DATA_W-1:0]    data_i,
   output logic signed [ACC_W-1:0]    sum_o,
   output logic                       valid_o
);

   logic signed [ACC_W-1:0] sum_d;
   logic signed [ACC_W-1:0] sum_q;
   logic                    valid_q;

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (mask_i[k]) begin
            sum_d = sum_d + ACC_W'($signed(data_i[k*DATA_W +: DATA_W]));
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= en_i && !flush_i;
         if (en_i) begin
            sum_q <= sum_d;
         end
      end
   end

   assign sum_o   = sum_q;
   assign valid_o = valid_q;

endmodule : iq_lane_sum
`default_nettype wire

// File: rtl/iq_integrator_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iq_integrator_pipe                                           |
// | Description : Multi-lane saturating I/Q integrator. Accumulates LANES      |
// |               rotated samples per beat over sample_length beats through a  |
// |               registered lane-sum stage; result held under valid/ready.    |
// | Ports       : clk100, reset (async active-low)                             |
// |               start/abort, sample_length, lane_mask   control              |
// |               in_valid, data_i, data_q                sample beats         |
// |               out_valid/out_ready, i_val, q_val, overflow  result          |
// |               busy, start_err                         status               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module iq_integrator_pipe
   import iq_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                       clk100,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [LEN_W-1:0]           sample_length,
   input  logic [LANES-1:0]           lane_mask,
   input  logic                       in_valid,
   input  logic [LANES*DATA_W-1:0]    data_i,
   input  logic [LANES*DATA_W-1:0]    data_q,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [ACC_W-1:0]    i_val,
   output logic signed [ACC_W-1:0]    q_val,
   output logic                       overflow,
   output logic                       busy,
   output logic                       start_err
);

   state_t                  state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LANES-1:0]        mask_q, mask_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
   logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
   logic                    ovf_q, ovf_d;
   logic                    err_q, err_d;

   logic                    accept_start;
   logic                    beat_ok;
   logic                    flush;
   logic signed [ACC_W-1:0] lsum_i, lsum_q;
   logic                    lsum_vi, lsum_vq;

   // ---------------- FSM: next state and control strobes ----------------
   always_comb begin
      state_d      = state_q;
      accept_start = 1'b0;
      beat_ok      = 1'b0;
      flush        = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_d      = (sample_length == '0) ? HOLD : INTEGRATE;
            end
         end
         INTEGRATE: begin
            if (in_valid) begin
               beat_ok = 1'b1;
               // Compare against len-1 so a full-scale length never needs
               // the counter to reach 2^LEN_W.
               if (cnt_q == len_q - LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN:   state_d = HOLD;
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE) begin
         err_d = start;
      end
      // abort outranks start, beat completion and handshake
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         beat_ok = 1'b0;
         flush   = 1'b1;
         err_d   = 1'b0;
      end
   end

   // ---------------- lane-sum stage ----------------
   iq_lane_sum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_sum_i (
      .clk_i   (clk100),
      .rst_ni  (reset),
      .flush_i (flush),
      .en_i    (beat_ok),
      .mask_i  (mask_q),
      .data_i  (data_i),
      .sum_o   (lsum_i),
      .valid_o (lsum_vi)
   );

   iq_lane_sum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_sum_q (
      .clk_i   (clk100),
      .rst_ni  (reset),
      .flush_i (flush),
      .en_i    (beat_ok),
      .mask_i  (mask_q),
      .data_i  (data_q),
      .sum_o   (lsum_q),
      .valid_o (lsum_vq)
   );

   // ---------------- datapath next state ----------------
   always_comb begin
      len_d   = len_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      ovf_d   = ovf_q;
      if (accept_start) begin
         len_d   = sample_length;
         mask_d  = lane_mask;
         cnt_d   = '0;
         acc_i_d = '0;
         acc_q_d = '0;
         ovf_d   = 1'b0;
      end else begin
         if (beat_ok) begin
            cnt_d = cnt_q + LEN_W'(1);
         end
         if (lsum_vi && lsum_vq && !flush) begin
            acc_i_d = ACC_W'(sat_add(64'(acc_i_q), 64'(lsum_i), ACC_W));
            acc_q_d = ACC_W'(sat_add(64'(acc_q_q), 64'(lsum_q), ACC_W));
            ovf_d   = ovf_q
                    | sat_ovf(64'(acc_i_q), 64'(lsum_i), ACC_W)
                    | sat_ovf(64'(acc_q_q), 64'(lsum_q), ACC_W);
         end
      end
   end

   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign i_val     = acc_i_q;
   assign q_val     = acc_q_q;
   assign overflow  = ovf_q;
   assign start_err = err_q;

endmodule : iq_integrator_pipe
`default_nettype wire
